block_draw_ctrl: RTL and testbench
==================================

BLOCK_DRAW_CTRL -- requirements
Module: block_draw_ctrl

Interface
REQ-001 SHALL have parameter X_MAX, default 156, largest legal block x origin (x+3 <= 159).
REQ-002 SHALL have parameter Y_MAX, default 116, largest legal block y origin (y+3 <= 119).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to run one erase/draw frame.
REQ-006 SHALL have port erase_en  input  1  when 1, erase tail block before drawing head (snake did not grow).
REQ-007 SHALL have ports head_x, tail_x  input  8 each  block origin x.
REQ-008 SHALL have ports head_y, tail_y  input  7 each  block origin y.
REQ-009 SHALL have ports fg_colour, bg_colour  input  3 each  head and erase colours.
REQ-010 SHALL have ports blk_x  output  8 and blk_y  output  7  block origin driven to the downstream 4x4 pixel datapath.
REQ-011 SHALL have port go  output  1  pixel-step enable to the downstream datapath.
REQ-012 SHALL have ports plot  output  1 and colour  output  3  VGA write strobe and pixel colour.
REQ-013 SHALL have ports busy  output  1 and done  output  1  frame in progress, and one-cycle frame-complete pulse.

Function
REQ-014 SHALL implement FSM states IDLE, ERASE, DRAW, FLUSH, DONE.
REQ-015 In IDLE, start=1 SHALL latch head/tail coordinates, colours and erase_en, then enter ERASE if erase_en=1, else DRAW.
REQ-016 start while not in IDLE SHALL be ignored; latched values SHALL NOT change mid-frame.
REQ-017 Latched x SHALL be min(x_in, X_MAX) with bits [1:0] forced to 0; latched y SHALL be min(y_in, Y_MAX) with bits [1:0] forced to 0.
REQ-018 ERASE and DRAW SHALL each last exactly 16 cycles, counted by a 4-bit counter, with go=1 on every one of those cycles.
REQ-019 During ERASE, blk_x/blk_y SHALL equal the latched tail; during DRAW, the latched head.
REQ-020 ERASE SHALL go directly to DRAW after count 15, with go held high continuously across the boundary (32 contiguous go cycles).
REQ-021 After DRAW count 15 the FSM SHALL enter FLUSH for exactly 1 cycle (go=0), then DONE for 1 cycle (done=1), then IDLE.
REQ-022 plot SHALL be go delayed by one clock, matching the downstream datapath's one-cycle registered pixel output.
REQ-023 colour SHALL be delayed with plot: bg_colour for pixels issued in ERASE, fg_colour for pixels in DRAW; colour SHALL be 0 when plot=0.
REQ-024 busy SHALL be 1 in ERASE, DRAW, FLUSH and DONE, and 0 in IDLE.
REQ-025 Frame length SHALL be 34 cycles from start (erase_en=1) or 18 cycles (erase_en=0), start edge to done pulse inclusive of FLUSH.
REQ-026 go count per block SHALL be exactly 16 so the downstream 2-bit row/col counters return to 0 at every block boundary.
REQ-027 start on the same cycle as DONE SHALL be ignored; a new frame SHALL begin only from IDLE.

Reset
REQ-028 reset=1 SHALL asynchronously force state IDLE, counter 0, and all outputs 0 (blk_x, blk_y, go, plot, colour, busy, done).
REQ-029 reset asserted mid-frame SHALL abort immediately; after release the block SHALL sit in IDLE and issue no go/plot until the next start.

Verification
REQ-030 start, erase_en=1, tail=(8,12), head=(12,12), bg=0, fg=2 -> 16 go cycles at (8,12) then 16 at (12,12); plot lags go by 1; colour 0 then 2; done 34 cycles after start.
REQ-031 start, erase_en=0, head=(40,20) -> no erase; 16 go cycles at (40,20); done 18 cycles after start; busy high throughout.
REQ-032 head=(158,119) -> blk_x=156, blk_y=116; head=(13,7) -> blk_x=12, blk_y=4.
REQ-033 second start pulses on cycles 5 and at DONE of a frame -> ignored; exactly one frame of go cycles is produced.
REQ-034 reset asserted at go cycle 10 of DRAW -> outputs 0 in the same cycle; idle after release; a following start yields a full normal frame.
REQ-035 model downstream datapath counters -> row/col = 0 at each block boundary and at the end of the frame.

Source files
------------

// File: rtl/block_draw_ctrl.sv
// block_draw_ctrl
//   Sequences one erase/draw frame for a 4x4 block renderer. On start (IDLE
//   only), the head/tail origins and colours are latched. The tail block is
//   then optionally erased (16 pixel steps), the head block is drawn (16 pixel
//   steps), and the FSM finishes with one flush cycle and a one-cycle done
//   pulse.
//   Ports:
//     clk, reset              clock, asynchronous active-high reset
//     start, erase_en         frame request, erase-tail-first select
//     head_x/y, tail_x/y      block origins (clamped and 4-aligned on latch)
//     fg_colour, bg_colour    draw and erase colours
//     blk_x, blk_y, go        block origin and pixel-step enable to datapath
//     plot, colour            VGA write strobe/colour (go delayed one cycle)
//     busy, done              frame in progress, frame-complete pulse
module block_draw_ctrl #(
  parameter int X_MAX = 156,
  parameter int Y_MAX = 116
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       erase_en,
  input  logic [7:0] head_x,
  input  logic [7:0] tail_x,
  input  logic [6:0] head_y,
  input  logic [6:0] tail_y,
  input  logic [2:0] fg_colour,
  input  logic [2:0] bg_colour,
  output logic [7:0] blk_x,
  output logic [6:0] blk_y,
  output logic       go,
  output logic       plot,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ERASE = 3'd1;
  localparam logic [2:0] DRAW  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);

  // Clamp to the last legal origin, then snap to the 4-pixel block grid.
  function automatic logic [7:0] clamp_x(input logic [7:0] v);
    logic [7:0] m;
    m = (v > XM) ? XM : v;
    return {m[7:2], 2'b00};
  endfunction

  function automatic logic [6:0] clamp_y(input logic [6:0] v);
    logic [6:0] m;
    m = (v > YM) ? YM : v;
    return {m[6:2], 2'b00};
  endfunction

  logic [2:0] state;
  logic [3:0] cnt;
  logic [7:0] hx_l, tx_l;
  logic [6:0] hy_l, ty_l;
  logic [2:0] fg_l, bg_l;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hx_l  <= 8'd0;
      tx_l  <= 8'd0;
      hy_l  <= 7'd0;
      ty_l  <= 7'd0;
      fg_l  <= 3'd0;
      bg_l  <= 3'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          hx_l  <= clamp_x(head_x);
          tx_l  <= clamp_x(tail_x);
          hy_l  <= clamp_y(head_y);
          ty_l  <= clamp_y(tail_y);
          fg_l  <= fg_colour;
          bg_l  <= bg_colour;
          cnt   <= 4'd0;
          state <= erase_en ? ERASE : DRAW;
        end
        // The counter wraps 15->0 on the ERASE->DRAW hop, so go stays high
        // across the boundary and the downstream row/col counters restart.
        ERASE: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= DRAW;
        end
        DRAW: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= FLUSH;
        end
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign go   = (state == ERASE) || (state == DRAW);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    blk_x = 8'd0;
    blk_y = 7'd0;
    if (state == ERASE) begin
      blk_x = tx_l;
      blk_y = ty_l;
    end else if (state == DRAW) begin
      blk_x = hx_l;
      blk_y = hy_l;
    end
  end

  // Align the strobe and colour with the datapath's registered pixel output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plot   <= 1'b0;
      colour <= 3'd0;
    end else begin
      plot   <= go;
      colour <= go ? ((state == ERASE) ? bg_l : fg_l) : 3'd0;
    end
  end

endmodule

// File: tb/tb_block_draw_ctrl.sv
module tb_block_draw_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, erase_en = 1'b0;
  logic [7:0] head_x = 8'd0, tail_x = 8'd0;
  logic [6:0] head_y = 7'd0, tail_y = 7'd0;
  logic [2:0] fg_colour = 3'd0, bg_colour = 3'd0;
  logic [7:0] blk_x;
  logic [6:0] blk_y;
  logic       go, plot, busy, done;
  logic [2:0] colour;

  block_draw_ctrl #(.X_MAX(156), .Y_MAX(116)) dut (
    .clk(clk), .reset(reset), .start(start), .erase_en(erase_en),
    .head_x(head_x), .tail_x(tail_x), .head_y(head_y), .tail_y(tail_y),
    .fg_colour(fg_colour), .bg_colour(bg_colour),
    .blk_x(blk_x), .blk_y(blk_y), .go(go), .plot(plot), .colour(colour),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int x; int y; int col;} ev_t;
  ev_t go_q[$];
  ev_t plot_q[$];
  int  done_q[$];

  int cyc = 0;
  int chk_cnt = 0, pass_cnt = 0;
  int busy_lo = 1, busy_hi = 0;
  int pix = 0;
  bit in_rst = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    chk_cnt++;
    if (a == e) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
  endtask

  function automatic int cl(input int v, input int m);
    int r;
    r = (v > m) ? m : v;
    return (r / 4) * 4;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents go/plot/done.
  always @(negedge clk) begin
    ev_t e;
    if (!in_rst) begin
      if (go) begin
        if (go_q.size() == 0) chk("go_unexpected", 1, 0);
        else begin
          e = go_q.pop_front();
          chk("go_cycle", cyc, e.cyc);
          chk("blk_x", int'(blk_x), e.x);
          chk("blk_y", int'(blk_y), e.y);
        end
        pix = (pix + 1) % 16;
      end
      if (plot) begin
        if (plot_q.size() == 0) chk("plot_unexpected", 1, 0);
        else begin
          e = plot_q.pop_front();
          chk("plot_cycle", cyc, e.cyc);
          chk("colour", int'(colour), e.col);
        end
      end else chk("colour_idle", int'(colour), 0);
      chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          chk("done_cycle", cyc, done_q.pop_front());
          // 4x4 row/col counters in the downstream datapath must be back at 0.
          chk("rowcol_zero", pix, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pushes the expected frame then drives it; optional extra start pulses
  // mid-frame and on the DONE cycle must be ignored. abort_at>0 asserts
  // reset at that frame-relative cycle.
  task automatic run_frame(input bit er, input int hx, input int hy,
                           input int tx, input int ty, input int fg,
                           input int bg, input bit dup, input int abort_at);
    int s, n;
    ev_t e;
    s = cyc;
    n = er ? 32 : 16;
    for (int i = 0; i < n; i++) begin
      if (er && i < 16) begin
        e.x = cl(tx, 156); e.y = cl(ty, 116); e.col = bg;
      end else begin
        e.x = cl(hx, 156); e.y = cl(hy, 116); e.col = fg;
      end
      e.cyc = s + 1 + i; go_q.push_back(e);
      e.cyc = s + 2 + i; plot_q.push_back(e);
    end
    done_q.push_back(s + n + 2);
    busy_lo = s + 1;
    busy_hi = s + n + 2;
    erase_en = er;
    head_x = 8'(hx); head_y = 7'(hy); tail_x = 8'(tx); tail_y = 7'(ty);
    fg_colour = 3'(fg); bg_colour = 3'(bg);
    for (int k = 0; k <= n + 3; k++) begin
      if (abort_at != 0 && k == abort_at) begin
        reset = 1'b1; in_rst = 1'b1;
        #1;
        chk("rst_go", int'(go), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_blk_x", int'(blk_x), 0);
        chk("rst_blk_y", int'(blk_y), 0);
        go_q.delete(); plot_q.delete(); done_q.delete();
        busy_lo = 1; busy_hi = 0; pix = 0;
        start = 1'b0;
        tick(); tick();
        reset = 1'b0; in_rst = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        return;
      end
      start = (k == 0) || (dup && (k == 5 || k == n + 2));
      if (k == 1) begin
        // Inputs wander mid-frame; the latched values must not follow.
        head_x = 8'($urandom); head_y = 7'($urandom);
        tail_x = 8'($urandom); tail_y = 7'($urandom);
        fg_colour = 3'($urandom); bg_colour = 3'($urandom);
        erase_en = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_go", int'(go), 0);
    chk("reset_plot", int'(plot), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_blk_x", int'(blk_x), 0);
    tick(); tick();
    reset = 1'b0; in_rst = 1'b0;
    tick(); tick();

    run_frame(1, 12, 12, 8, 12, 2, 0, 1, 0);
    run_frame(0, 40, 20, 0, 0, 5, 1, 0, 0);
    run_frame(0, 158, 119, 0, 0, 7, 0, 0, 0);
    run_frame(1, 13, 7, 255, 127, 3, 6, 1, 0);
    for (int f = 0; f < 12; f++) begin
      run_frame(1'($urandom), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), 1'($urandom), 0);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end
    // Reset during the 10th go cycle of DRAW, then a normal frame.
    run_frame(0, 60, 60, 0, 0, 4, 0, 0, 10);
    run_frame(1, 100, 40, 20, 80, 1, 2, 0, 0);
    tick(); tick();

    chk("go_q_empty", go_q.size(), 0);
    chk("plot_q_empty", plot_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
